// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - run/pause/alarm sequencer and count-enable source for the DOWN_CNT chain
module countdown_ctrl #(
    parameter int PRESCALE    = 100_000_000,
    parameter int REPEAT_DLY  = 50_000_000,
    parameter int REPEAT_RATE = 10_000_000,
    parameter int ALARM_LEN   = 10
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       BTN_START,
    input  logic       BTN_ZERO,
    input  logic       BTN_ADJ,
    input  logic       CHAIN_ZERO,
    output logic       CHAIN_CE,
    output logic       CHAIN_CLR,
    output logic       RUNNING,
    output logic       ALARM,
    output logic [1:0] STATE
);

    localparam int PW   = $clog2(PRESCALE) + 1;
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam int AW   = $clog2(ALARM_LEN) + 1;

    localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
    localparam logic [AW-1:0] AL_LAST   = AW'(ALARM_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [RW-1:0] rep;
    logic          rep_on;
    logic [AW-1:0] alarm_cnt;
    logic          adj_q;
    logic          presc_wrap;
    logic          rep_hit;

    assign presc_wrap = (presc == PS_LAST);
    // rep_on selects between the initial hold delay and the steady repeat period
    assign rep_hit    = rep_on ? (rep == RATE_LAST) : (rep == DLY_LAST);
    assign STATE      = state;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= S_IDLE;
            presc     <= '0;
            rep       <= '0;
            rep_on    <= 1'b0;
            alarm_cnt <= '0;
            adj_q     <= 1'b0;
            CHAIN_CE  <= 1'b0;
            CHAIN_CLR <= 1'b0;
            RUNNING   <= 1'b0;
            ALARM     <= 1'b0;
        end else begin
            adj_q     <= BTN_ADJ;
            CHAIN_CE  <= 1'b0;
            CHAIN_CLR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (BTN_ZERO) begin
                        CHAIN_CLR <= 1'b1;
                        rep       <= '0;
                        rep_on    <= 1'b0;
                    end else if (BTN_START && !CHAIN_ZERO) begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                        presc   <= '0;
                        rep     <= '0;
                        rep_on  <= 1'b0;
                    end else if (!BTN_ADJ) begin
                        rep    <= '0;
                        rep_on <= 1'b0;
                    end else if (!adj_q) begin
                        CHAIN_CE <= 1'b1;
                        rep      <= RW'(1);
                        rep_on   <= 1'b0;
                    end else if (rep_hit) begin
                        CHAIN_CE <= 1'b1;
                        rep      <= '0;
                        rep_on   <= 1'b1;
                    end else begin
                        rep <= rep + 1'b1;
                    end
                end
                S_RUN: begin
                    if (BTN_ZERO) begin
                        CHAIN_CLR <= 1'b1;
                        state     <= S_IDLE;
                        RUNNING   <= 1'b0;
                        presc     <= '0;
                    end else if (BTN_START) begin
                        state   <= S_PAUSE;
                        RUNNING <= 1'b0;
                    end else if (CHAIN_ZERO) begin
                        state     <= S_ALARM;
                        RUNNING   <= 1'b0;
                        ALARM     <= 1'b1;
                        alarm_cnt <= '0;
                        presc     <= '0;
                    end else if (presc_wrap) begin
                        presc    <= '0;
                        CHAIN_CE <= 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (BTN_ZERO) begin
                        CHAIN_CLR <= 1'b1;
                        state     <= S_IDLE;
                        presc     <= '0;
                    end else if (BTN_START) begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                    end
                end
                S_ALARM: begin
                    if (BTN_ZERO || BTN_START) begin
                        CHAIN_CLR <= BTN_ZERO;
                        state     <= S_IDLE;
                        ALARM     <= 1'b0;
                        presc     <= '0;
                    end else if (presc_wrap) begin
                        presc <= '0;
                        if (alarm_cnt == AL_LAST) begin
                            state <= S_IDLE;
                            ALARM <= 1'b0;
                        end else begin
                            alarm_cnt <= alarm_cnt + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed bench for countdown_ctrl driving a 2-digit down-counter model
module tb_countdown_ctrl;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        BTN_START = 1'b0;
    logic        BTN_ZERO = 1'b0;
    logic        BTN_ADJ = 1'b0;
    logic        CHAIN_ZERO;
    logic        CHAIN_CE;
    logic        CHAIN_CLR;
    logic        RUNNING;
    logic        ALARM;
    logic [1:0]  STATE;

    int          chain = 0;
    logic        load = 1'b0;
    int          load_val = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mask;
    int          bad;

    always #5 CLK = ~CLK;

    countdown_ctrl #(
        .PRESCALE(4),
        .REPEAT_DLY(6),
        .REPEAT_RATE(3),
        .ALARM_LEN(2)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .BTN_START(BTN_START),
        .BTN_ZERO(BTN_ZERO),
        .BTN_ADJ(BTN_ADJ),
        .CHAIN_ZERO(CHAIN_ZERO),
        .CHAIN_CE(CHAIN_CE),
        .CHAIN_CLR(CHAIN_CLR),
        .RUNNING(RUNNING),
        .ALARM(ALARM),
        .STATE(STATE)
    );

    assign CHAIN_ZERO = (chain == 0);

    always @(posedge CLK) begin
        if (load)           chain <= load_val;
        else if (CHAIN_CLR) chain <= 0;
        else if (CHAIN_CE)  chain <= (chain == 0) ? 99 : chain - 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        BTN_START = 1'b1;
        @(negedge CLK);
        BTN_START = 1'b0;
    endtask

    task automatic load_chain(input int v);
        load     = 1'b1;
        load_val = v;
        @(negedge CLK);
        load     = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        CLR = 1'b0;
        chk("rst_state", STATE, 0);
        chk("rst_ce", CHAIN_CE, 0);
        chk("rst_clr", CHAIN_CLR, 0);
        chk("rst_running", RUNNING, 0);
        chk("rst_alarm", ALARM, 0);

        // 1: CLR in the middle of RUN
        load_chain(5);
        pulse_start();
        chk("t1_run", STATE, 1);
        cyc();
        cyc();
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        chk("t1_state", STATE, 0);
        chk("t1_ce", CHAIN_CE, 0);
        chk("t1_running", RUNNING, 0);
        cyc();
        chk("t1_chain_kept", chain, 5);

        // 2: run 03 down to alarm and auto-return
        load_chain(3);
        pulse_start();
        chk("t2_run", STATE, 1);
        mask = '0;
        for (int n = 1; n <= 22; n++) begin
            cyc();
            mask[n] = CHAIN_CE;
            if (n == 13) begin
                chk("t2_chain_zero", chain, 0);
                chk("t2_state13", STATE, 1);
            end
            if (n == 14) begin
                chk("t2_state14", STATE, 3);
                chk("t2_alarm14", ALARM, 1);
            end
            if (n == 21) chk("t2_state21", STATE, 3);
            if (n == 22) begin
                chk("t2_state22", STATE, 0);
                chk("t2_alarm22", ALARM, 0);
            end
        end
        chk("t2_ce_pos", mask, 32'h0000_1110);

        // 3: hold ADJ from 00 for 16 cycles
        BTN_ADJ = 1'b1;
        mask = '0;
        for (int n = 0; n < 16; n++) begin
            cyc();
            mask[n] = CHAIN_CE;
        end
        BTN_ADJ = 1'b0;
        chk("t3_ce_pos", mask, 32'h0000_4921);
        mask = '0;
        for (int n = 0; n < 5; n++) begin
            cyc();
            mask[n] = CHAIN_CE;
        end
        chk("t3_ce_after_release", mask, 0);
        chk("t3_chain", chain, 95);

        // 4: pause at prescaler=2 and resume
        pulse_start();
        chk("t4_run", STATE, 1);
        cyc();
        cyc();
        pulse_start();
        chk("t4_pause", STATE, 2);
        chk("t4_pause_running", RUNNING, 0);
        mask = '0;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            mask[n] = CHAIN_CE;
            if (STATE != 2'd2) bad++;
        end
        chk("t4_pause_ce", mask, 0);
        chk("t4_pause_hold", bad, 0);
        pulse_start();
        chk("t4_resume", STATE, 1);
        chk("t4_resume_running", RUNNING, 1);
        chk("t4_ce_r0", CHAIN_CE, 0);
        cyc();
        chk("t4_ce_r1", CHAIN_CE, 0);
        cyc();
        chk("t4_first_ce", CHAIN_CE, 1);
        cyc();
        chk("t4_chain", chain, 94);

        // 5: START and ZERO together in RUN
        BTN_START = 1'b1;
        BTN_ZERO  = 1'b1;
        cyc();
        BTN_START = 1'b0;
        BTN_ZERO  = 1'b0;
        chk("t5_clr", CHAIN_CLR, 1);
        chk("t5_ce", CHAIN_CE, 0);
        chk("t5_state", STATE, 0);
        chk("t5_running", RUNNING, 0);
        cyc();
        chk("t5_clr_1cyc", CHAIN_CLR, 0);
        chk("t5_state2", STATE, 0);
        chk("t5_chain", chain, 0);

        // 6: START ignored with chain at 00
        pulse_start();
        chk("t6_state", STATE, 0);
        mask = '0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            mask[n] = CHAIN_CE;
            if (STATE != 2'd0) bad++;
        end
        chk("t6_ce", mask, 0);
        chk("t6_hold", bad, 0);

        // alarm acknowledged by START, then ZERO in IDLE
        load_chain(1);
        pulse_start();
        repeat (6) cyc();
        chk("t7_alarm_state", STATE, 3);
        chk("t7_alarm", ALARM, 1);
        pulse_start();
        chk("t7_ack_state", STATE, 0);
        chk("t7_ack_alarm", ALARM, 0);
        chk("t7_ack_clr", CHAIN_CLR, 0);
        load_chain(7);
        BTN_ZERO = 1'b1;
        cyc();
        BTN_ZERO = 1'b0;
        chk("t8_idle_clr", CHAIN_CLR, 1);
        chk("t8_idle_state", STATE, 0);
        cyc();
        chk("t8_chain", chain, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
